// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory store path.
//
// Contents:
//   BYTE_LANES  - byte lanes per data word (fixed at 4)
//   WORD_OFFSET - low byte-address bits that select a lane inside a word
//   SB_ADDR_W   - byte-address width the buffer entries are built for
//   SB_DATA_W   - data width the buffer entries are built for
//   sb_entry_t  - one store buffer slot (valid, word address, data, enables)
//   sb_state_t  - store buffer control states (RUN, FENCE)
package mem_pkg;

    localparam int BYTE_LANES  = 4;
    localparam int WORD_OFFSET = 2;
    localparam int SB_ADDR_W   = 32;
    localparam int SB_DATA_W   = 8 * BYTE_LANES;
    localparam int SB_WORD_W   = SB_ADDR_W - WORD_OFFSET;

    typedef struct packed {
        logic                  valid;
        logic [SB_WORD_W-1:0]  word_addr;
        logic [SB_DATA_W-1:0]  data;
        logic [BYTE_LANES-1:0] byte_en;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FENCE = 1'b1
    } sb_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store port bundle between the core MEM stage, the store buffer and
// data_memory.
//
// Signals:
//   push_valid/push_ready      - store handshake from the core
//   push_addr/data/byte_en     - the store being offered
//   mem_grant                  - memory write port is free this cycle
//   mem_store_instruction      - write enable towards data_memory
//   mem_address/data_in/byte_en- head entry presented to data_memory
//
// Modports:
//   master - core/memory side (drives push and grant)
//   slave  - the store buffer itself
interface store_buffer_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
);
    logic                  push_valid;
    logic                  push_ready;
    logic [ADDR_W-1:0]     push_addr;
    logic [DATA_W-1:0]     push_data;
    logic [BYTE_LANES-1:0] push_byte_en;

    logic                  mem_grant;
    logic                  mem_store_instruction;
    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W-1:0]     mem_data_in;
    logic [BYTE_LANES-1:0] mem_byte_en;

    modport master (
        output push_valid, push_addr, push_data, push_byte_en, mem_grant,
        input  push_ready, mem_store_instruction, mem_address, mem_data_in,
               mem_byte_en
    );

    modport slave (
        input  push_valid, push_addr, push_data, push_byte_en, mem_grant,
        output push_ready, mem_store_instruction, mem_address, mem_data_in,
               mem_byte_en
    );

endinterface

// File: rtl/sb_forward_merge.sv
// Store-to-load forwarding merge for the store buffer.
//
// For every byte lane, selects the byte from the youngest occupied entry
// whose word address matches the load and whose enable covers that lane.
//
// Ports:
//   entries  - the full entry array, indexed by FIFO pointer
//   head     - pointer of the oldest occupied entry
//   count    - number of occupied entries
//   ld_word  - load word address (byte address without the lane bits)
//   fwd_data - merged bytes, zero in uncovered lanes
//   fwd_mask - lanes supplied by the buffer
module sb_forward_merge
    import mem_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int PTR_W   = $clog2(ENTRIES),
    parameter int CNT_W   = PTR_W + 1
) (
    input  sb_entry_t             entries [ENTRIES],
    input  logic [PTR_W-1:0]      head,
    input  logic [CNT_W-1:0]      count,
    input  logic [SB_WORD_W-1:0]  ld_word,
    output logic [SB_DATA_W-1:0]  fwd_data,
    output logic [BYTE_LANES-1:0] fwd_mask
);

    logic [PTR_W-1:0] idx;

    // Walk the entries oldest to youngest so a later match overwrites an
    // earlier one lane by lane; the last writer of each lane is the youngest.
    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        idx      = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && entries[idx].valid &&
                (entries[idx].word_addr == ld_word)) begin
                for (int l = 0; l < BYTE_LANES; l++) begin
                    if (entries[idx].byte_en[l]) begin
                        fwd_data[8*l +: 8] = entries[idx].data[8*l +: 8];
                        fwd_mask[l]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer on the data-memory write port.
//
// Queues retired stores from the core, writes them to data_memory one per
// granted cycle in FIFO order, forwards pending bytes to loads, and drains
// completely on a fence request.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   sb         - push handshake and memory write port (slave modport)
//   ld_addr    - load byte address to forward against
//   fwd_data   - buffered bytes for the load, zero in uncovered lanes
//   fwd_mask   - lanes supplied by the buffer
//   fence      - level request to drain everything
//   fence_done - one-cycle pulse when a fence completes
//   empty/full - occupancy flags
//   count      - number of occupied entries
//
// The entry struct fixes address and data widths at the mem_pkg values,
// so ADDR_W and DATA_W must match SB_ADDR_W and SB_DATA_W.
module store_buffer
    import mem_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = SB_ADDR_W,
    parameter int DATA_W  = SB_DATA_W,
    parameter int CNT_W   = $clog2(ENTRIES) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    store_buffer_if.slave         sb,
    input  logic [ADDR_W-1:0]     ld_addr,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [BYTE_LANES-1:0] fwd_mask,
    input  logic                  fence,
    output logic                  fence_done,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(ENTRIES);

    sb_entry_t        entries_q [ENTRIES];
    sb_entry_t        entries_d [ENTRIES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    sb_state_t        state_q, state_d;

    sb_entry_t        head_entry;
    logic             push_fire;
    logic             push_keep;
    logic             pop;
    logic             unused_lane_bits;

    // Lane-select bits of byte addresses never matter to a word-wide buffer.
    assign unused_lane_bits = ^{ld_addr[WORD_OFFSET-1:0],
                                sb.push_addr[WORD_OFFSET-1:0]};

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(ENTRIES));

    // The memory port always shows the head entry; it only commits when
    // something is queued and the port is granted.
    assign head_entry               = entries_q[head_q];
    assign pop                      = !empty && sb.mem_grant;
    assign sb.mem_store_instruction = pop;
    assign sb.mem_address           = {head_entry.word_addr, {WORD_OFFSET{1'b0}}};
    assign sb.mem_data_in           = head_entry.data;
    assign sb.mem_byte_en           = head_entry.byte_en;

    // A handshake with no byte enabled completes but leaves nothing behind.
    assign push_fire = sb.push_valid && sb.push_ready;
    assign push_keep = push_fire && (|sb.push_byte_en);

    // Control FSM. A fence stops new pushes and waits for the registered
    // count to reach zero. Reset is folded in so that push_ready and
    // fence_done stay low while reset is held.
    always_comb begin
        state_d       = state_q;
        sb.push_ready = 1'b0;
        fence_done    = 1'b0;
        if (reset) begin
            case (state_q)
                RUN: begin
                    sb.push_ready = !full;
                    if (fence) begin
                        if (empty) begin
                            fence_done = 1'b1;
                        end else begin
                            state_d = FENCE;
                        end
                    end
                end
                FENCE: begin
                    if (empty) begin
                        fence_done = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // FIFO next state. Push never lands on the popped slot: the pointers
    // only coincide when empty (no pop) or full (no push).
    always_comb begin
        entries_d = entries_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
        end
        if (push_keep) begin
            entries_d[tail_q].valid     = 1'b1;
            entries_d[tail_q].word_addr = sb.push_addr[ADDR_W-1:WORD_OFFSET];
            entries_d[tail_q].data      = sb.push_data;
            entries_d[tail_q].byte_en   = sb.push_byte_en;
        end
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push_keep);
        count_d = count_q + CNT_W'(push_keep) - CNT_W'(pop);
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= RUN;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    sb_forward_merge #(
        .ENTRIES (ENTRIES),
        .PTR_W   (PTR_W),
        .CNT_W   (CNT_W)
    ) u_forward (
        .entries  (entries_q),
        .head     (head_q),
        .count    (count_q),
        .ld_word  (ld_addr[ADDR_W-1:WORD_OFFSET]),
        .fwd_data (fwd_data),
        .fwd_mask (fwd_mask)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer: push/drain, forwarding, full and
// wrap behaviour, zero-enable drop, fence drain and asynchronous reset.
module tb_store_buffer;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] ld_addr;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_mask;
    logic        fence;
    logic        fence_done;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    int tests_run;
    int tests_failed;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) sbi ();

    store_buffer #(
        .ENTRIES (4),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sb         (sbi.slave),
        .ld_addr    (ld_addr),
        .fwd_data   (fwd_data),
        .fwd_mask   (fwd_mask),
        .fence      (fence),
        .fence_done (fence_done),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every committed memory write in order.
    always @(posedge clk) begin
        if (sbi.mem_store_instruction) begin
            wr_addr_q.push_back(sbi.mem_address);
            wr_data_q.push_back(sbi.mem_data_in);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one store for a single clock edge; caller ensures push_ready.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] be);
        sbi.push_valid   = 1'b1;
        sbi.push_addr    = addr;
        sbi.push_data    = data;
        sbi.push_byte_en = be;
        @(posedge clk);
        #1;
        sbi.push_valid = 1'b0;
    endtask

    function automatic logic [31:0] wrAddrAt(input int i);
        return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] wrDataAt(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hDEAD_DEAD;
    endfunction

    int pulses;
    int ready_leak;
    int writes_at_done;
    bit fence_seen;

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset            = 1'b0;
        fence            = 1'b0;
        ld_addr          = '0;
        sbi.push_valid   = 1'b0;
        sbi.push_addr    = '0;
        sbi.push_data    = '0;
        sbi.push_byte_en = '0;
        sbi.mem_grant    = 1'b0;

        // Reset state
        #2;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_push_ready", 32'(sbi.push_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(sbi.mem_store_instruction), 32'd0);
        checkOutput("rst_mem_addr", sbi.mem_address, 32'd0);
        checkOutput("rst_fwd_mask", 32'(fwd_mask), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("post_rst_push_ready", 32'(sbi.push_ready), 32'd1);

        // Single store, held then drained
        applyStimulus(32'h100, 32'hCAFE_BABE, 4'hF);
        checkOutput("single_count", 32'(count), 32'd1);
        checkOutput("single_mem_addr", sbi.mem_address, 32'h100);
        checkOutput("single_mem_data", sbi.mem_data_in, 32'hCAFE_BABE);
        checkOutput("single_mem_we_nogrant", 32'(sbi.mem_store_instruction), 32'd0);
        sbi.mem_grant = 1'b1;
        #1;
        checkOutput("single_mem_we_grant", 32'(sbi.mem_store_instruction), 32'd1);
        @(posedge clk);
        #1;
        sbi.mem_grant = 1'b0;
        checkOutput("single_empty", 32'(empty), 32'd1);
        checkOutput("single_writes", 32'(wr_addr_q.size()), 32'd1);
        checkOutput("single_wr_addr", wrAddrAt(0), 32'h100);
        checkOutput("single_wr_data", wrDataAt(0), 32'hCAFE_BABE);

        // Forwarding: lane merge and youngest-wins
        applyStimulus(32'h104, 32'h0000_00AA, 4'h1);
        applyStimulus(32'h104, 32'h0000_BB00, 4'h2);
        ld_addr = 32'h105;
        #1;
        checkOutput("fwd_mask_merge", 32'(fwd_mask), 32'h3);
        checkOutput("fwd_data_merge", fwd_data, 32'h0000_BBAA);
        applyStimulus(32'h104, 32'h0000_00CC, 4'h1);
        checkOutput("fwd_data_youngest", fwd_data, 32'h0000_BBCC);
        checkOutput("fwd_count3", 32'(count), 32'd3);
        ld_addr = 32'h200;
        #1;
        checkOutput("fwd_miss_mask", 32'(fwd_mask), 32'h0);
        checkOutput("fwd_miss_data", fwd_data, 32'h0);
        sbi.mem_grant = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sbi.mem_grant = 1'b0;
        checkOutput("fwd_drained", 32'(empty), 32'd1);

        // Fill to full, hold a fifth push, release one slot
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h10 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4'hF);
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_push_ready", 32'(sbi.push_ready), 32'd0);
        sbi.push_valid   = 1'b1;
        sbi.push_addr    = 32'h20;
        sbi.push_data    = 32'h5555_5555;
        sbi.push_byte_en = 4'hF;
        @(posedge clk);
        #1;
        checkOutput("fill_held_count", 32'(count), 32'd4);
        sbi.mem_grant = 1'b1;
        #1;
        checkOutput("fill_pop_we", 32'(sbi.mem_store_instruction), 32'd1);
        checkOutput("fill_no_bypass", 32'(sbi.push_ready), 32'd0);
        checkOutput("fill_pop_addr", sbi.mem_address, 32'h10);
        @(posedge clk);
        #1;
        sbi.mem_grant = 1'b0;
        checkOutput("fill_after_pop_count", 32'(count), 32'd3);
        checkOutput("fill_after_pop_ready", 32'(sbi.push_ready), 32'd1);
        @(posedge clk);
        #1;
        sbi.push_valid = 1'b0;
        checkOutput("fill_fifth_count", 32'(count), 32'd4);
        checkOutput("fill_fifth_full", 32'(full), 32'd1);
        checkOutput("fill_head_addr", sbi.mem_address, 32'h14);
        ld_addr = 32'h20;
        #1;
        checkOutput("fill_fwd_fifth", fwd_data, 32'h5555_5555);
        checkOutput("fill_fwd_fifth_mask", 32'(fwd_mask), 32'hF);
        ld_addr = 32'h10;
        #1;
        checkOutput("fill_fwd_popped", 32'(fwd_mask), 32'h0);
        sbi.mem_grant = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sbi.mem_grant = 1'b0;
        checkOutput("fill_drained", 32'(empty), 32'd1);
        checkOutput("fill_writes", 32'(wr_addr_q.size()), 32'd5);
        checkOutput("fill_wr0", wrAddrAt(0), 32'h10);
        checkOutput("fill_wr3", wrAddrAt(3), 32'h1C);
        checkOutput("fill_wr4", wrAddrAt(4), 32'h20);
        checkOutput("fill_wr4_data", wrDataAt(4), 32'h5555_5555);

        // Zero byte-enable store is accepted and dropped
        wr_addr_q.delete();
        wr_data_q.delete();
        sbi.push_valid   = 1'b1;
        sbi.push_addr    = 32'h0;
        sbi.push_data    = 32'h1234_5678;
        sbi.push_byte_en = 4'h0;
        sbi.mem_grant    = 1'b1;
        #1;
        checkOutput("zero_be_ready", 32'(sbi.push_ready), 32'd1);
        @(posedge clk);
        #1;
        sbi.push_valid = 1'b0;
        checkOutput("zero_be_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        sbi.mem_grant = 1'b0;
        checkOutput("zero_be_writes", 32'(wr_addr_q.size()), 32'd0);

        // Fence with a toggling grant
        applyStimulus(32'h40, 32'hA0, 4'hF);
        applyStimulus(32'h44, 32'hA4, 4'hF);
        applyStimulus(32'h48, 32'hA8, 4'hF);
        wr_addr_q.delete();
        wr_data_q.delete();
        fence = 1'b1;
        #1;
        checkOutput("fence_no_early_done", 32'(fence_done), 32'd0);
        pulses         = 0;
        ready_leak     = 0;
        writes_at_done = -1;
        fence_seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            sbi.mem_grant = i[0];
            #1;
            if (!fence_seen && sbi.push_ready) ready_leak++;
            if (fence_done) begin
                pulses++;
                if (!fence_seen) begin
                    fence_seen     = 1'b1;
                    writes_at_done = wr_addr_q.size();
                    fence          = 1'b0;
                end
            end
        end
        sbi.mem_grant = 1'b0;
        fence         = 1'b0;
        checkOutput("fence_pulses", 32'(pulses), 32'd1);
        checkOutput("fence_writes_at_done", 32'(writes_at_done), 32'd3);
        checkOutput("fence_ready_blocked", 32'(ready_leak), 32'd0);
        checkOutput("fence_wr0", wrAddrAt(0), 32'h40);
        checkOutput("fence_wr1", wrAddrAt(1), 32'h44);
        checkOutput("fence_wr2", wrAddrAt(2), 32'h48);
        checkOutput("fence_ready_after", 32'(sbi.push_ready), 32'd1);

        // Asynchronous reset in the middle of a drain
        applyStimulus(32'h80, 32'hB0, 4'hF);
        applyStimulus(32'h84, 32'hB4, 4'hF);
        checkOutput("arst_count_before", 32'(count), 32'd2);
        wr_addr_q.delete();
        wr_data_q.delete();
        sbi.mem_grant = 1'b1;
        #1;
        checkOutput("arst_we_before", 32'(sbi.mem_store_instruction), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_empty", 32'(empty), 32'd1);
        checkOutput("arst_we", 32'(sbi.mem_store_instruction), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sbi.mem_grant = 1'b0;
        checkOutput("arst_no_writes", 32'(wr_addr_q.size()), 32'd0);
        checkOutput("arst_still_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
